// File: rtl/bf16_mul_arbiter_if.sv
// Bundle between client engines, the shared BF16 multiplier and the result consumer.
// Operand slices are packed per requester so req_a[i] is bits [16i+15:16i].
interface bf16_mul_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][15:0] req_a;
   logic [NUM_REQ-1:0][15:0] req_b;
   logic [15:0]              mul_a;
   logic [15:0]              mul_b;
   logic [15:0]              mul_result;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [15:0]              rsp_data;
   logic [ID_W-1:0]          rsp_id;
   logic                     busy;

   modport slave (
      input  req_valid, req_a, req_b, mul_result, rsp_ready,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, mul_result, rsp_ready,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/bf16_mul_arbiter.sv
// Round-robin scheduler sharing one combinational BF16 multiplier among NUM_REQ clients.
// One operation in flight; operands are held MUL_LAT cycles before the product is sampled.
module bf16_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   bf16_mul_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          r_state, w_state_nxt;
   logic [ID_W-1:0] r_ptr, w_ptr_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic [15:0]     r_mul_a, w_mul_a_nxt;
   logic [15:0]     r_mul_b, w_mul_b_nxt;
   logic [15:0]     r_rsp_data, w_rsp_data_nxt;
   logic [ID_W-1:0] r_rsp_id, w_rsp_id_nxt;

   logic [NUM_REQ-1:0] w_zero_a;
   logic [NUM_REQ-1:0] w_zero_b;
   logic [NUM_REQ-1:0] w_ready;
   logic [ID_W-1:0]    w_gnt;
   logic               w_any;
   logic [15:0]        w_gnt_a;
   logic [15:0]        w_gnt_b;

   // Per-requester zero detect (magnitude only; sign is carried separately)
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign w_zero_a[gi] = ~|bus.req_a[gi][14:0];
         assign w_zero_b[gi] = ~|bus.req_b[gi][14:0];
      end
   endgenerate

   // Walk from farthest to nearest so the requester closest to ptr wins
   always_comb begin
      logic [ID_W:0] sum;
      w_gnt = '0;
      w_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
         if (bus.req_valid[sum[ID_W-1:0]]) begin
            w_any = 1'b1;
            w_gnt = sum[ID_W-1:0];
         end
      end
   end

   assign w_gnt_a = bus.req_a[w_gnt];
   assign w_gnt_b = bus.req_b[w_gnt];

   always_comb begin
      w_ready = '0;
      if (i_rst_n && (r_state == IDLE) && w_any) w_ready[w_gnt] = 1'b1;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_cnt_nxt      = r_cnt;
      w_mul_a_nxt    = r_mul_a;
      w_mul_b_nxt    = r_mul_b;
      w_rsp_data_nxt = r_rsp_data;
      w_rsp_id_nxt   = r_rsp_id;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_mul_a_nxt  = w_gnt_a;
               w_mul_b_nxt  = w_gnt_b;
               w_rsp_id_nxt = w_gnt;
               w_ptr_nxt    = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
               if (w_zero_a[w_gnt] || w_zero_b[w_gnt]) begin
                  w_rsp_data_nxt = {w_gnt_a[15] ^ w_gnt_b[15], 15'b0};
                  w_state_nxt    = RESP;
               end else begin
                  w_cnt_nxt   = 4'(MUL_LAT);
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_rsp_data_nxt = bus.mul_result;
               w_state_nxt    = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_rsp_data <= '0;
         r_rsp_id   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mul_a    <= w_mul_a_nxt;
         r_mul_b    <= w_mul_b_nxt;
         r_rsp_data <= w_rsp_data_nxt;
         r_rsp_id   <= w_rsp_id_nxt;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.mul_a     = r_mul_a;
   assign bus.mul_b     = r_mul_b;
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_bf16_mul_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int MUL_LAT = 2;

   typedef struct {
      logic [15:0]     data;
      logic [ID_W-1:0] id;
      int              lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bf16_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   bf16_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   exp_t q_exp[$];
   int   q_acc[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   logic prev_v = 1'b0;

   // Normal-number BF16 product, truncating; vectors below are all exact
   function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] p;
      logic [9:0]  e;
      logic [6:0]  f;
      if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {a[15] ^ b[15], 15'b0};
      p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
      e = 10'(a[14:7]) + 10'(b[14:7]) - 10'd127;
      if (p[15]) begin
         f = p[14:8];
         e = e + 10'd1;
      end else begin
         f = p[13:7];
      end
      return {a[15] ^ b[15], e[7:0], f};
   endfunction

   always_comb bus.mul_result = bf_mul(bus.mul_a, bus.mul_b);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic push_exp(input logic [15:0] d, input int id, input int lat);
      exp_t e;
      e.data = d;
      e.id   = ID_W'(id);
      e.lat  = lat;
      q_exp.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         q_acc.delete();
         prev_v = 1'b0;
      end else begin
         if (|(bus.req_valid & bus.req_ready)) q_acc.push_back(cyc);
         if (bus.rsp_valid) begin
            if (q_exp.size() == 0) begin
               fail("unexpected_rsp");
            end else begin
               if (!prev_v) begin
                  if (q_acc.size() == 0) fail("rsp_without_accept");
                  else chk("latency", cyc - q_acc[0], q_exp[0].lat);
               end
               if (bus.rsp_ready) begin
                  chk("rsp_data", bus.rsp_data, q_exp[0].data);
                  chk("rsp_id", bus.rsp_id, q_exp[0].id);
                  void'(q_exp.pop_front());
                  if (q_acc.size() > 0) void'(q_acc.pop_front());
               end
            end
         end
         prev_v = bus.rsp_valid && !bus.rsp_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int id);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_valid[id] && bus.req_ready[id]) return;
      end
      fail("accept_timeout");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus.busy) return;
      end
      fail("idle_timeout");
   endtask

   task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int lat);
      push_exp(exp, id, lat);
      bus.req_a[id]     = a;
      bus.req_b[id]     = b;
      bus.req_valid[id] = 1'b1;
      wait_acc(id);
      if (lat > 1) begin
         @(negedge clk);
         chk("mul_a_held", bus.mul_a, a);
         chk("mul_b_held", bus.mul_b, b);
      end
      tick();
      bus.req_valid[id] = 1'b0;
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.rsp_ready = 1'b1;
      bus.req_valid = '1;
      bus.req_a[0]  = 16'h4000;
      bus.req_b[0]  = 16'h4000;
      for (int i = 1; i < NUM_REQ; i++) begin
         bus.req_a[i] = 16'h3F80;
         bus.req_b[i] = 16'h3F80;
      end

      // Reset with everyone valid, then first grant goes to requester 0
      repeat (2) begin
         @(negedge clk);
         chk("rst_req_ready", bus.req_ready, 4'b0000);
         chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
         chk("rst_busy", bus.busy, 1'b0);
      end
      chk("rst_mul_a", bus.mul_a, 16'h0);
      chk("rst_rsp_data", bus.rsp_data, 16'h0);
      chk("rst_rsp_id", bus.rsp_id, 2'd0);
      push_exp(16'h4080, 0, MUL_LAT + 1);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      wait_idle();

      // Single op through the multiplier: 3.0 * 2.0
      tick();
      do_op(2, 16'h4040, 16'h4000, 16'h40C0, MUL_LAT + 1);

      // Continuous contention from a fresh pointer
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.req_a[0] = 16'h3FC0; bus.req_b[0] = 16'h3FC0;
      bus.req_a[1] = 16'hBF80; bus.req_b[1] = 16'h4040;
      bus.req_a[2] = 16'h3F00; bus.req_b[2] = 16'h4080;
      bus.req_a[3] = 16'h4000; bus.req_b[3] = 16'h4000;
      push_exp(16'h4010, 0, MUL_LAT + 1);
      push_exp(16'hC040, 1, MUL_LAT + 1);
      push_exp(16'h4000, 2, MUL_LAT + 1);
      push_exp(16'h4080, 3, MUL_LAT + 1);
      push_exp(16'h4010, 0, MUL_LAT + 1);
      bus.req_valid = '1;
      n = 0;
      for (int i = 0; i < 60 && n < 5; i++) begin
         @(negedge clk);
         if (|(bus.req_valid & bus.req_ready)) n++;
      end
      chk("rr_accepts", n, 5);
      tick();
      bus.req_valid = '0;
      wait_idle();

      // Backpressure with requester 0 pending behind requester 1
      tick();
      bus.rsp_ready = 1'b0;
      push_exp(16'h4110, 1, MUL_LAT + 1);
      push_exp(16'h4040, 0, MUL_LAT + 1);
      bus.req_a[1] = 16'h4040; bus.req_b[1] = 16'h4040;
      bus.req_valid[1] = 1'b1;
      wait_acc(1);
      tick();
      bus.req_valid[1] = 1'b0;
      bus.req_a[0] = 16'h3F80; bus.req_b[0] = 16'h4040;
      bus.req_valid[0] = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            n = 1;
            break;
         end
      end
      if (n == 0) fail("bp_rsp_timeout");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
         chk("bp_rsp_data", bus.rsp_data, 16'h4110);
         chk("bp_rsp_id", bus.rsp_id, 2'd1);
         chk("bp_req_ready", bus.req_ready, 4'b0000);
      end
      tick();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("accept_after_bp", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid[0] = 1'b0;
      wait_idle();

      // Zero bypass: signed zero, one-cycle response
      tick();
      do_op(3, 16'h8000, 16'h3F80, 16'h8000, 1);
      tick();
      do_op(0, 16'hC040, 16'h0000, 16'h8000, 1);

      // Reset while waiting on the multiplier
      tick();
      bus.req_a[2] = 16'h4040; bus.req_b[2] = 16'h4000;
      bus.req_valid[2] = 1'b1;
      wait_acc(2);
      tick();
      bus.req_valid[2] = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
         chk("abort_busy", bus.busy, 1'b0);
      end
      tick();
      push_exp(16'h3E80, 0, MUL_LAT + 1);
      bus.req_a[0] = 16'h3F00; bus.req_b[0] = 16'h3F00;
      bus.req_valid = '1;
      @(negedge clk);
      chk("ptr_after_abort", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      wait_idle();

      tick();
      chk("scoreboard_drained", q_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
